// File: rtl/graying_binarize_pkg.sv
// Shared image package for the graying / binarize / morphology chain.
// Contents:
//   - default frame-size and pixel-width constants used by every stage
//   - calc_pixel_bits : log2 of the pixel count of a frame (width bits + height bits)
//   - all_ones        : all-ones pixel value for a given pixel width
//   - work mode codes for the binarize threshold source
package graying_binarize_pkg;

  localparam int default_color_width    = 8;
  localparam int default_im_width_bits  = 9;
  localparam int default_im_height_bits = 9;

  // Threshold source selection.
  localparam int mode_fixed    = 0;
  localparam int mode_adaptive = 1;

  // Frame dimensions are powers of two, so the pixel count is 2^(w+h).
  function automatic int calc_pixel_bits(input int w_bits, input int h_bits);
    return w_bits + h_bits;
  endfunction

  // All-ones value for a pixel of the given width (1..32 bits).
  function automatic logic [31:0] all_ones(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/graying_binarize_if.sv
// Pixel stream bundle between the graying stage, the binarize stage and
// its consumer.
//   in_enable     : in_data valid this cycle (no back-pressure)
//   in_sof        : start of frame, qualified by in_enable
//   in_data       : gray pixel
//   out_ready     : out_data valid this cycle
//   out_data      : binarized pixel (all-ones or zero)
//   out_threshold : threshold currently in use
//   frame_done    : one-cycle pulse with the output of a frame's last pixel
// Modports: master = stream source / result sink, slave = binarize block.
interface graying_binarize_if #(
  parameter int color_width = 8
);
  logic                   in_enable;
  logic                   in_sof;
  logic [color_width-1:0] in_data;
  logic                   out_ready;
  logic [color_width-1:0] out_data;
  logic [color_width-1:0] out_threshold;
  logic                   frame_done;

  modport master (
    output in_enable,
    output in_sof,
    output in_data,
    input  out_ready,
    input  out_data,
    input  out_threshold,
    input  frame_done
  );

  modport slave (
    input  in_enable,
    input  in_sof,
    input  in_data,
    output out_ready,
    output out_data,
    output out_threshold,
    output frame_done
  );
endinterface

// File: rtl/graying_binarize_frame_mean_acc.sv
// frame_mean_acc: pixel counter, frame accumulator and threshold register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_enable  : pixel accepted this cycle
//   in_sof     : start of frame (qualified by in_enable)
//   in_data    : gray pixel
//   threshold  : threshold to compare the current pixel against
//   last_pixel : the pixel accepted this cycle closes a frame
// In adaptive mode the threshold becomes the mean of the frame just
// completed; since the pixel count is a power of two the mean is a shift.
module frame_mean_acc
  import graying_binarize_pkg::*;
#(
  parameter int work_mode      = mode_fixed,
  parameter int color_width    = default_color_width,
  parameter int pixel_bits     = calc_pixel_bits(default_im_width_bits, default_im_height_bits),
  parameter int init_threshold = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enable,
  input  logic                   in_sof,
  input  logic [color_width-1:0] in_data,
  output logic [color_width-1:0] threshold,
  output logic                   last_pixel
);

  localparam int acc_width = color_width + pixel_bits;
  localparam logic [pixel_bits-1:0] cnt_last = '1;

  logic [pixel_bits-1:0] cnt_reg;
  logic [acc_width-1:0]  acc_reg;
  logic [acc_width-1:0]  acc_sum;

  // Sum including the pixel of this cycle; on the last pixel it is the frame total.
  assign acc_sum = acc_reg + acc_width'(in_data);

  // Start of frame overrides the wrap: that pixel is index 0 of a new frame.
  assign last_pixel = in_enable && !in_sof && (cnt_reg == cnt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      acc_reg <= '0;
    end else if (in_enable) begin
      if (in_sof) begin
        cnt_reg <= pixel_bits'(1);
        acc_reg <= acc_width'(in_data);
      end else if (last_pixel) begin
        cnt_reg <= '0;
        acc_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= acc_sum;
      end
    end
  end

  generate
    if (work_mode == mode_adaptive) begin : g_adaptive
      logic [color_width-1:0] threshold_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          threshold_reg <= color_width'(init_threshold);
        end else if (last_pixel) begin
          // Frame mean, truncated toward zero.
          threshold_reg <= color_width'(acc_sum >> pixel_bits);
        end
      end

      assign threshold = threshold_reg;
    end else begin : g_fixed
      assign threshold = color_width'(init_threshold);
    end
  endgenerate

endmodule

// File: rtl/graying_binarize.sv
// graying_binarize: two-level thresholding of a gray pixel stream.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of graying_binarize_if
//              (in_enable/in_sof/in_data in; out_ready/out_data/
//               out_threshold/frame_done out)
// A pixel strictly above the threshold becomes all-ones, otherwise zero.
// One cycle of latency; the threshold is fixed or the previous frame mean.
module graying_binarize
  import graying_binarize_pkg::*;
#(
  parameter int work_mode      = mode_fixed,
  parameter int color_width    = default_color_width,
  parameter int im_width_bits  = default_im_width_bits,
  parameter int im_height_bits = default_im_height_bits,
  parameter int init_threshold = 128
) (
  input logic               clk,
  input logic               rst,
  graying_binarize_if.slave bus
);

  localparam int pixel_bits = calc_pixel_bits(im_width_bits, im_height_bits);
  localparam logic [color_width-1:0] pixel_ones = color_width'(all_ones(color_width));

  logic [color_width-1:0] threshold;
  logic                   last_pixel;

  logic                   out_ready_reg;
  logic [color_width-1:0] out_data_reg;
  logic                   frame_done_reg;

  frame_mean_acc #(
    .work_mode      (work_mode),
    .color_width    (color_width),
    .pixel_bits     (pixel_bits),
    .init_threshold (init_threshold)
  ) u_frame_mean_acc (
    .clk        (clk),
    .rst        (rst),
    .in_enable  (bus.in_enable),
    .in_sof     (bus.in_sof),
    .in_data    (bus.in_data),
    .threshold  (threshold),
    .last_pixel (last_pixel)
  );

  // The threshold register updates on the same edge as these outputs, so the
  // last pixel of a frame is still compared against the old threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ready_reg  <= 1'b0;
      out_data_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      out_ready_reg  <= bus.in_enable;
      out_data_reg   <= (bus.in_enable && (bus.in_data > threshold)) ? pixel_ones : '0;
      frame_done_reg <= last_pixel;
    end
  end

  assign bus.out_ready     = out_ready_reg;
  assign bus.out_data      = out_data_reg;
  assign bus.frame_done    = frame_done_reg;
  assign bus.out_threshold = threshold;

endmodule

// File: doc/graying_binarize.md
# graying_binarize

Downstream of the graying stage: consumes its `color_width`-bit gray stream and emits a two-level pixel stream (all-ones / zero) for the morphology and edge stages. The compare threshold is either a fixed parameter or, in adaptive mode, the mean gray level of the previous complete frame. Frame dimensions are powers of two, so the mean is a shift with no divider.

## Interface
Parameters:
- `work_mode`, 0: 0 = fixed threshold; 1 = adaptive previous-frame mean.
- `color_width`, 8: gray pixel width.
- `im_width_bits`, 9: log2 of frame width.
- `im_height_bits`, 9: log2 of frame height. `P = im_width_bits + im_height_bits`; frame holds `2^P` pixels.
- `init_threshold`, 128: fixed threshold (mode 0), and threshold after reset (mode 1).

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_enable` in 1: `in_data` is valid this cycle (per-cycle valid, no back-pressure).
- `in_sof` in 1: start of frame; qualified by `in_enable`.
- `in_data` in `color_width`: gray pixel.
- `out_ready` out 1: `out_data` is valid this cycle.
- `out_data` out `color_width`: all-ones if pixel > threshold, else 0.
- `out_threshold` out `color_width`: threshold currently in use.
- `frame_done` out 1: one-cycle pulse, output of the last pixel of a frame.

## Operation
- Compare: `out_data = (in_data > threshold) ? all-ones : 0`. The compare is strict, so a pixel equal to the threshold maps to 0.
- Pixel counter `cnt`, P bits:
  - Increments on each `in_enable`.
  - On `in_enable && in_sof`, the pixel is treated as index 0 and `cnt` becomes 1.
  - The last pixel of a frame is the one accepted with `cnt == 2^P-1`; `cnt` then wraps to 0.
- Accumulator `acc`, `color_width+P` bits, cannot overflow:
  - Adds `in_data` on each `in_enable`.
  - On `in_sof`, it loads `in_data`, discarding the partial frame.
  - On the last pixel, `acc` clears to 0.
- Threshold update:
  - Mode 1: on the last pixel, `threshold <= (acc + in_data) >> P`, truncated toward zero.
  - Mode 0: `threshold` is constant `init_threshold`. `acc` and `cnt` still run so that `frame_done` works.
- The new threshold applies from the first pixel accepted after the last-pixel cycle. The last pixel itself is compared against the old threshold.
- `in_sof` together with `cnt == 2^P-1`: `in_sof` wins. The pixel is index 0, there is no threshold update and no `frame_done`.
- `in_sof` with `in_enable` low is ignored.

## Timing
- Latency is 1 cycle. Pixel accepted at edge N appears with `out_ready` high after edge N (cycle N+1).
- Throughput is 1 pixel/clk. Gaps in `in_enable` pass through as gaps in `out_ready`.
- `out_data` is 0 whenever `out_ready` is low.
- `frame_done` is high in the same cycle as the `out_ready` of the frame's last pixel.
- `out_threshold` changes in the same cycle as that `frame_done`.
- Reset values: `out_ready`=0, `out_data`=0, `frame_done`=0, `out_threshold`=`init_threshold`, `cnt`=0, `acc`=0.
- Reset mid-frame drops all state, including a pixel accepted in the reset cycle. The next pixel is index 0 whether or not `in_sof` is asserted.

## Structure
- Shared image package holds:
  - The `P` derivation.
  - The all-ones pixel constant function of `color_width`.
  - The default frame-size constants, shared with graying and later stages.
- One sub-module, `frame_mean_acc`: owns the counter, accumulator and threshold register. It exports `threshold` and `last_pixel`.
- The top level holds the compare and the output registers.

## Test plan
All scenarios use `im_width_bits=2`, `im_height_bits=2` (16 pixels) and `color_width=8` unless noted.
1. Mode 0, `init_threshold=100`, inputs 99, 100, 101 on consecutive cycles → `out_data` 0, 0, 255 on the next three cycles; `out_ready` high for those three cycles only.
2. Mode 1, reset, then 16 pixels of 200 with `in_sof` on the first:
   - → all 16 outputs are 255 (threshold 128).
   - → `frame_done` and `out_threshold`=200 on the 16th output.
   - Next frame of 16×200 → all 0.
3. Mode 1, frame of 0..15 → sum 120, `out_threshold`=7. Following pixel 8 → 255; following pixel 7 → 0.
4. `in_enable` toggled every other cycle through a full frame → exactly 16 `out_ready` pulses, one `frame_done`, and the threshold update is identical to scenario 3.
5. `in_sof` mid-frame after 10 pixels of 255, then 16 pixels of 10 → no `frame_done` at pixel 16 of the stream; `out_threshold`=10 after the resync frame.
6. Assert `rst` for one cycle mid-frame while `in_enable` is high → next cycle `out_ready`=0 and `out_threshold`=128. A 16-pixel frame without `in_sof` then completes with `frame_done`.
